router_port_reader: RTL and testbench

Destination-side consumer for one router output port. It watches the port's `vld_out` and drains one complete packet from the port FIFO using `read_enb`: header, then payload, then parity. It streams the payload bytes to a local sink and reports length, parity and address status for each packet. One instance sits on each of the three router output ports.

---
 rtl/router_port_reader.sv | 146 ++++++++++++++
 tb/tb_router_port_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_reader.sv
// Destination-side reader for one router output port: drains header, payload and
// parity from the port FIFO, streams the payload to a local sink and reports status.
module router_port_reader #(
  parameter logic [1:0]  PORT_ADDR   = 2'b00,
  parameter int unsigned START_DELAY = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       pkt_done,
  output logic [5:0] pkt_len,
  output logic       parity_err,
  output logic       addr_err,
  output logic       pkt_drop,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HDR,
    S_HCAP,
    S_PAY,
    S_PAR,
    S_CHK
  } state_t;

  localparam logic [4:0] WAIT_LAST = (START_DELAY == 0) ? 5'd0 : 5'(START_DELAY - 1);

  state_t     r_state;
  logic [4:0] r_wait_cnt;
  logic [5:0] r_len;
  logic [5:0] r_issued;
  logic [7:0] r_acc;
  logic       r_addr_ok;
  logic       r_byte_valid;
  logic       r_pkt_done;
  logic [5:0] r_pkt_len;
  logic       r_parity_err;
  logic       r_addr_err;
  logic       r_pkt_drop;

  logic       w_read_enb;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_read_enb = 1'b0;
    unique case (r_state)
      S_HDR, S_PAR: w_read_enb = vld_out;
      S_PAY:        w_read_enb = vld_out & sink_ready & (r_issued < r_len);
      default:      w_read_enb = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: resetn is sampled only on the clock edge; all state uses non-blocking assignments.
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_len        <= '0;
      r_issued     <= '0;
      r_acc        <= '0;
      r_addr_ok    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_len    <= '0;
      r_parity_err <= 1'b0;
      r_addr_err   <= 1'b0;
      r_pkt_drop   <= 1'b0;
    end else begin
      r_pkt_done   <= 1'b0;
      r_pkt_drop   <= 1'b0;
      // A payload read already issued still returns its byte, even across an abort.
      r_byte_valid <= (r_state == S_PAY) && w_read_enb;

      if (r_byte_valid && (r_state == S_PAY || r_state == S_PAR))
        r_acc <= r_acc ^ data_out;

      if (soft_reset && r_state != S_IDLE) begin
        r_state    <= S_IDLE;
        r_wait_cnt <= '0;
        r_len      <= '0;
        r_issued   <= '0;
        r_acc      <= '0;
        r_pkt_drop <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (vld_out && !soft_reset) begin
              r_wait_cnt <= '0;
              r_state    <= (START_DELAY == 0) ? S_HDR : S_WAIT;
            end
          end
          S_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) r_state <= S_HDR;
            else                         r_wait_cnt <= r_wait_cnt + 5'd1;
          end
          S_HDR: begin
            if (w_read_enb) r_state <= S_HCAP;
          end
          S_HCAP: begin
            r_len     <= data_out[7:2];
            r_issued  <= '0;
            r_acc     <= data_out;
            r_addr_ok <= (data_out[1:0] == PORT_ADDR);
            r_state   <= (data_out[7:2] == 6'd0) ? S_PAR : S_PAY;
          end
          S_PAY: begin
            if (w_read_enb) begin
              r_issued <= r_issued + 6'd1;
              if (r_issued == r_len - 6'd1) r_state <= S_PAR;
            end
          end
          S_PAR: begin
            if (w_read_enb) r_state <= S_CHK;
          end
          S_CHK: begin
            r_pkt_done   <= 1'b1;
            r_parity_err <= (data_out != r_acc);
            r_addr_err   <= !r_addr_ok;
            r_pkt_len    <= r_len;
            r_state      <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign read_enb   = w_read_enb;
  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_valid ? data_out : 8'h00;
  assign pkt_done   = r_pkt_done;
  assign pkt_len    = r_pkt_len;
  assign parity_err = r_parity_err;
  assign addr_err   = r_addr_err;
  assign pkt_drop   = r_pkt_drop;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_router_port_reader.sv
// Bench for router_port_reader: a port FIFO model feeds packets, and a transaction-level
// model of packets and payload bytes is compared against the DUT outputs every cycle.
module tb_router_port_reader;

  localparam logic [1:0] PORT_ADDR   = 2'b00;
  localparam int         START_DELAY = 2;

  logic       clock = 1'b0;
  logic       resetn, vld_out, soft_reset, sink_ready;
  logic [7:0] data_out;
  logic       read_enb, byte_valid, pkt_done, parity_err, addr_err, pkt_drop, busy;
  logic [7:0] byte_data;
  logic [5:0] pkt_len;

  always #5 clock = ~clock;

  router_port_reader #(.PORT_ADDR(PORT_ADDR), .START_DELAY(START_DELAY)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .soft_reset (soft_reset),
    .sink_ready (sink_ready),
    .read_enb   (read_enb),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_drop   (pkt_drop),
    .busy       (busy)
  );

  typedef struct {
    int len;
    bit perr;
    bit aerr;
  } pkt_t;

  pkt_t       exp_pkts[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] fifo[$];
  logic [7:0] src[$];
  logic [7:0] pay_buf[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit rd_pending = 1'b0;
  int seen     = 0;
  bit prev_sink = 1'b0;
  logic [5:0] held_len  = '0;
  bit         held_perr = 1'b0;
  bit         held_aerr = 1'b0;

  int re_log[$], bv_log[$], done_log[$], drop_log[$];
  int done_len_log[$];
  bit done_perr_log[$], done_aerr_log[$];
  bit busy_at[int];
  int got_cyc[$], exp_cyc[$];

  int c0, c1, r, rlen, budget;
  logic [7:0] rhdr, rpar, x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected by the model (cycle %0d)", name, cyc);
  endtask

  // One clock cycle of the port FIFO: a read sampled at the edge returns data just after it.
  task automatic tick();
    @(negedge clock);
    rd_pending = read_enb;
    @(posedge clock);
    #1;
    cyc++;
    if (rd_pending && fifo.size() != 0) data_out = fifo.pop_front();
    if (src.size() != 0 && $urandom_range(0, 3) != 0) fifo.push_back(src.pop_front());
    vld_out = (fifo.size() != 0);
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] par, input bit direct);
    pkt_t p;
    logic [7:0] acc;
    logic [7:0] all[$];
    acc = hdr;
    all.push_back(hdr);
    foreach (pay_buf[i]) begin
      acc ^= pay_buf[i];
      all.push_back(pay_buf[i]);
      exp_bytes.push_back(pay_buf[i]);
    end
    all.push_back(par);
    p.len  = int'(hdr[7:2]);
    p.perr = (par != acc);
    p.aerr = (hdr[1:0] != PORT_ADDR);
    exp_pkts.push_back(p);
    foreach (all[i]) begin
      if (direct) fifo.push_back(all[i]);
      else        src.push_back(all[i]);
    end
    if (direct) vld_out = 1'b1;
  endtask

  task automatic discard_front();
    if (exp_pkts.size() != 0) begin
      for (int i = seen; i < exp_pkts[0].len; i++) void'(exp_bytes.pop_front());
      void'(exp_pkts.pop_front());
    end
    seen = 0;
  endtask

  task automatic clear_logs();
    re_log.delete(); bv_log.delete(); done_log.delete(); drop_log.delete();
    done_len_log.delete(); done_perr_log.delete(); done_aerr_log.delete();
    busy_at.delete();
  endtask

  task automatic check_cycles(input string name, input int base);
    check({name, " count"}, got_cyc.size(), exp_cyc.size());
    for (int i = 0; i < got_cyc.size() && i < exp_cyc.size(); i++)
      check(name, got_cyc[i] - base, exp_cyc[i]);
  endtask

  // Compare process: checks every DUT output against the packet/byte model each cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      busy_at[cyc] = busy;
      if (read_enb) begin
        re_log.push_back(cyc);
        check("read_enb only with vld_out", vld_out, 1);
      end
      if (byte_valid) begin
        bv_log.push_back(cyc);
        check("byte_valid follows sink_ready", prev_sink, 1);
        if (exp_pkts.size() == 0 || exp_bytes.size() == 0 || seen >= exp_pkts[0].len)
          fail_now("extra payload byte");
        else begin
          check("payload byte", byte_data, exp_bytes.pop_front());
          seen++;
        end
      end
      if (pkt_done) begin
        done_log.push_back(cyc);
        done_len_log.push_back(int'(pkt_len));
        done_perr_log.push_back(parity_err);
        done_aerr_log.push_back(addr_err);
        if (exp_pkts.size() == 0) fail_now("pkt_done");
        else begin
          check("pkt_len", pkt_len, exp_pkts[0].len);
          check("parity_err", parity_err, exp_pkts[0].perr);
          check("addr_err", addr_err, exp_pkts[0].aerr);
          check("bytes delivered before pkt_done", seen, exp_pkts[0].len);
          held_len  = 6'(exp_pkts[0].len);
          held_perr = exp_pkts[0].perr;
          held_aerr = exp_pkts[0].aerr;
          void'(exp_pkts.pop_front());
          seen = 0;
        end
      end else begin
        check("pkt_len hold", pkt_len, held_len);
        check("parity_err hold", parity_err, held_perr);
        check("addr_err hold", addr_err, held_aerr);
      end
      if (pkt_drop) begin
        drop_log.push_back(cyc);
        if (exp_pkts.size() == 0) fail_now("pkt_drop");
        else discard_front();
      end
      if (!resetn) begin
        discard_front();
        held_len  = '0;
        held_perr = 1'b0;
        held_aerr = 1'b0;
      end
    end
    prev_sink = sink_ready;
  end

  initial begin
    resetn = 1'b0; vld_out = 1'b0; data_out = 8'h00; soft_reset = 1'b0; sink_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("reset read_enb", read_enb, 0);
    check("reset byte_valid", byte_valid, 0);
    check("reset byte_data", byte_data, 0);
    check("reset pkt_done", pkt_done, 0);
    check("reset pkt_len", pkt_len, 0);
    check("reset parity_err", parity_err, 0);
    check("reset addr_err", addr_err, 0);
    check("reset pkt_drop", pkt_drop, 0);
    check("reset busy", busy, 0);
    resetn = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // Clean packet, fully ready.
    clear_logs(); c0 = cyc;
    pay_buf = '{8'h11, 8'h22, 8'h33};
    push_pkt(8'h0C, 8'h0C, 1'b1);
    repeat (14) tick();
    got_cyc = re_log;   exp_cyc = '{3, 5, 6, 7, 8}; check_cycles("clean read_enb cycle", c0);
    got_cyc = bv_log;   exp_cyc = '{6, 7, 8};       check_cycles("clean byte_valid cycle", c0);
    got_cyc = done_log; exp_cyc = '{10};            check_cycles("clean pkt_done cycle", c0);
    if (done_len_log.size() == 1) begin
      check("clean pkt_len literal", done_len_log[0], 3);
      check("clean parity_err literal", done_perr_log[0], 0);
      check("clean addr_err literal", done_aerr_log[0], 0);
    end else fail_now("clean pkt_done missing");

    // Zero-length packet.
    clear_logs(); c0 = cyc;
    pay_buf.delete();
    push_pkt(8'h00, 8'h00, 1'b1);
    repeat (12) tick();
    got_cyc = re_log;   exp_cyc = '{3, 5}; check_cycles("zero read_enb cycle", c0);
    got_cyc = bv_log;   exp_cyc = {};      check_cycles("zero byte_valid cycle", c0);
    got_cyc = done_log; exp_cyc = '{7};    check_cycles("zero pkt_done cycle", c0);
    if (done_len_log.size() == 1) check("zero pkt_len literal", done_len_log[0], 0);
    else fail_now("zero pkt_done missing");

    // Bad parity and wrong address.
    clear_logs(); c0 = cyc;
    pay_buf = '{8'hA5};
    push_pkt(8'h06, 8'h00, 1'b1);
    repeat (12) tick();
    got_cyc = done_log; exp_cyc = '{8}; check_cycles("bad pkt_done cycle", c0);
    if (done_len_log.size() == 1) begin
      check("bad pkt_len literal", done_len_log[0], 1);
      check("bad parity_err literal", done_perr_log[0], 1);
      check("bad addr_err literal", done_aerr_log[0], 1);
    end else fail_now("bad pkt_done missing");

    // Backpressure: sink drops for five cycles after the second payload byte.
    clear_logs(); c0 = cyc;
    pay_buf = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_pkt(8'h10, 8'h14, 1'b1);
    for (int k = 0; k < 22; k++) begin
      tick();
      r = cyc - c0;
      sink_ready = !(r >= 7 && r <= 11);
    end
    sink_ready = 1'b1;
    got_cyc = re_log;   exp_cyc = '{3, 5, 6, 12, 13, 14}; check_cycles("stall read_enb cycle", c0);
    got_cyc = bv_log;   exp_cyc = '{6, 7, 13, 14};        check_cycles("stall byte_valid cycle", c0);
    got_cyc = done_log; exp_cyc = '{16};                  check_cycles("stall pkt_done cycle", c0);

    // Abort by soft_reset while in PAY, then re-arm.
    clear_logs(); c0 = cyc;
    pay_buf = '{8'h41, 8'h42, 8'h43, 8'h44};
    push_pkt(8'h10, 8'h14, 1'b1);
    for (int k = 0; k < 14; k++) begin
      tick();
      r = cyc - c0;
      soft_reset = (r == 6);
      if (r == 7) begin
        fifo.delete();
        vld_out = 1'b0;
      end
    end
    got_cyc = drop_log; exp_cyc = '{7};       check_cycles("abort pkt_drop cycle", c0);
    got_cyc = done_log; exp_cyc = {};         check_cycles("abort pkt_done cycle", c0);
    got_cyc = bv_log;   exp_cyc = '{6, 7};    check_cycles("abort byte_valid cycle", c0);
    got_cyc = re_log;   exp_cyc = '{3, 5, 6}; check_cycles("abort read_enb cycle", c0);
    check("abort busy before", busy_at[c0 + 6], 1);
    check("abort busy after", busy_at[c0 + 7], 0);

    clear_logs(); c1 = cyc;
    pay_buf = '{8'h5A, 8'h3C};
    push_pkt(8'h08, 8'h6E, 1'b1);
    repeat (14) tick();
    got_cyc = done_log; exp_cyc = '{9}; check_cycles("rearm pkt_done cycle", c1);

    // Reset for one cycle in the middle of PAY.
    clear_logs(); c0 = cyc;
    pay_buf = '{8'h91, 8'h92, 8'h93, 8'h94};
    push_pkt(8'h10, 8'h14, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      r = cyc - c0;
      resetn = !(r == 6);
      if (r == 7) begin
        fifo.delete();
        vld_out = 1'b0;
        #1;
        check("midreset read_enb", read_enb, 0);
        check("midreset byte_valid", byte_valid, 0);
        check("midreset byte_data", byte_data, 0);
        check("midreset pkt_done", pkt_done, 0);
        check("midreset pkt_drop", pkt_drop, 0);
        check("midreset pkt_len", pkt_len, 0);
        check("midreset parity_err", parity_err, 0);
        check("midreset addr_err", addr_err, 0);
        check("midreset busy", busy, 0);
      end
    end
    got_cyc = drop_log; exp_cyc = {};    check_cycles("midreset pkt_drop cycle", c0);
    got_cyc = done_log; exp_cyc = {};    check_cycles("midreset pkt_done cycle", c0);
    got_cyc = bv_log;   exp_cyc = '{6};  check_cycles("midreset byte_valid cycle", c0);

    // Random packets trickling into the FIFO with a random sink.
    for (int p = 0; p < 30; p++) begin
      rlen = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 8);
      rhdr = {6'(rlen), 2'($urandom_range(0, 3))};
      pay_buf.delete();
      x = rhdr;
      for (int i = 0; i < rlen; i++) begin
        pay_buf.push_back(8'($urandom_range(0, 255)));
        x ^= pay_buf[i];
      end
      rpar = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
      push_pkt(rhdr, rpar, 1'b0);
    end
    budget = 20000;
    while (exp_pkts.size() != 0 && budget > 0) begin
      tick();
      sink_ready = ($urandom_range(0, 4) != 0);
      budget--;
    end
    sink_ready = 1'b1;
    check("random packets all completed", exp_pkts.size(), 0);
    check("random fifo drained", fifo.size() + src.size(), 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
